// File: rtl/memory_access_arbiter_pkg.sv
// Shared definitions for the two-port memory access arbiter: default widths
// and the controller state encoding.
package memory_access_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Writes finish straight after the strobe cycle; reads wait one cycle for RAM data.
    function automatic state_t state_after_access(input logic is_write);
        return is_write ? ST_DONE : ST_READ_WAIT;
    endfunction

endpackage

// File: rtl/memory_access_arbiter_arbiter.sv
// Two-way winner selection with a last-served record for round-robin ties.
module arbiter_2way (
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic fixed_priority,
    input  logic update,
    input  logic served,
    output logic winner
);

    // 0 = port a served last, 1 = port b served last
    logic last_q;
    logic last_d;

    // Record the owner of each completed transaction.
    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = served;
        end
    end

    // Last-served register; starts as b so that a wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // Lone requester wins; ties go to a (fixed) or to the port not served last.
    always_comb begin
        winner = 1'b0;
        if (req_b && !req_a) begin
            winner = 1'b1;
        end else if (req_a && req_b && !fixed_priority) begin
            winner = ~last_q;
        end
    end

endmodule

// File: rtl/memory_access_arbiter.sv
// Arbitrates two requesters onto one single-port RAM with one-cycle
// registered read. Each transaction walks IDLE -> ACCESS -> (READ_WAIT) -> DONE.
module memory_access_arbiter
    import memory_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  write_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  write_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  grant,
    output logic                  busy
);

    state_t                state_q;
    state_t                state_d;
    logic                  write_q;
    logic                  grant_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_din_q;
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;

    logic any_req;
    logic winner;
    logic start;
    logic done_cycle;

    assign any_req    = req_a | req_b;
    assign start      = (state_q == ST_IDLE) && any_req;
    assign done_cycle = (state_q == ST_DONE);

    arbiter_2way u_arbiter (
        .clock          (clock),
        .reset          (reset),
        .req_a          (req_a),
        .req_b          (req_b),
        .fixed_priority (FIXED_PRIORITY != 0),
        .update         (done_cycle),
        .served         (grant_q),
        .winner         (winner)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (any_req) state_d = ST_ACCESS;
            ST_ACCESS:    state_d = state_after_access(write_q);
            ST_READ_WAIT: state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's operands at arbitration and capture read data in READ_WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q    <= 1'b0;
            grant_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            if (start) begin
                grant_q    <= winner;
                write_q    <= winner ? write_b : write_a;
                ram_addr_q <= winner ? addr_b  : addr_a;
                ram_din_q  <= winner ? wdata_b : wdata_a;
            end
            if (state_q == ST_READ_WAIT) begin
                if (grant_q) begin
                    rdata_b_q <= ram_dout;
                end else begin
                    rdata_a_q <= ram_dout;
                end
            end
        end
    end

    // Outputs; strobes are masked by reset so an aborted transaction is silent
    // even during the cycle in which reset is being sampled.
    always_comb begin
        ram_write_en = (state_q == ST_ACCESS) && write_q && !reset;
        ack_a        = done_cycle && !grant_q && !reset;
        ack_b        = done_cycle &&  grant_q && !reset;
        busy         = (state_q != ST_IDLE);
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign grant    = grant_q;

endmodule
